sync_fifo: RTL and testbench

Single-clock first-in/first-out buffer that decouples a producer and a consumer running on the same clock. It stores 4-bit words by default and presents them in write order on a registered output. Full and empty flags drive upstream and downstream flow control. It is used as a generic small elastic buffer between datapath stages.

---
 rtl/sync_fifo.sv | 61 ++++++
 tb/tb_sync_fifo.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered read port.
// Full/empty come from extended-MSB read and write pointers.
module sync_fifo #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 8,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_a,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE =
        {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  =
        (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
        (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

    // A read frees a slot this cycle, so a full FIFO still accepts
    // a write when rd_en is high.
    assign do_wr = wr_en && (!full || rd_en);
    assign do_rd = rd_en && !empty;

    // Storage array; no reset since stale words never reach data_out.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    // Pointers and the output register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            data_out <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                rd_ptr   <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: table-driven vectors plus reset sequences
// for the 4-bit x 8 sync_fifo.
module tb_sync_fifo;

    logic       clk;
    logic       rst_a;
    logic       wr_en;
    logic       rd_en;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic       full;
    logic       empty;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [3:0] din;
        logic [3:0] dout;
        logic       full;
        logic       empty;
    } vec_t;

    vec_t vq[$];

    sync_fifo #(.DATA_WIDTH(4), .DEPTH(8)) dut (
        .clk      (clk),
        .rst_a    (rst_a),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic add(input logic w, input logic r,
                       input logic [3:0] d, input logic [3:0] e,
                       input logic f, input logic m);
        vec_t v;
        v.wr = w; v.rd = r; v.din = d;
        v.dout = e; v.full = f; v.empty = m;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [3:0] ed,
                       input logic ef, input logic ee);
        n_total++;
        if (data_out === ed && full === ef && empty === ee) begin
            n_pass++;
        end else begin
            $display("FAIL %s: data_out=%h full=%b empty=%b, want %h %b %b",
                     nm, data_out, full, empty, ed, ef, ee);
        end
    endtask

    task automatic step(input logic w, input logic r,
                        input logic [3:0] d);
        @(negedge clk);
        wr_en = w; rd_en = r; data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = 4'h0;

        for (int i = 1; i <= 8; i++) add(1, 0, 4'(i), 4'h0, i == 8, 0);
        for (int i = 0; i < 10; i++) add(1, 0, 4'(9 + i), 4'h0, 1, 0);
        for (int i = 1; i <= 8; i++) add(0, 1, 4'h0, 4'(i), 0, i == 8);
        add(0, 1, 4'h0, 4'h8, 0, 1);
        for (int i = 1; i <= 5; i++) add(1, 0, 4'(i), 4'h8, 0, 0);
        for (int i = 1; i <= 5; i++) add(0, 1, 4'h0, 4'(i), 0, i == 5);
        for (int i = 1; i <= 8; i++) add(1, 0, 4'(9 + i), 4'h5, i == 8, 0);
        for (int i = 1; i <= 8; i++) add(0, 1, 4'h0, 4'(9 + i), 0, i == 8);
        add(1, 0, 4'h3, 4'h1, 0, 0);
        add(1, 0, 4'h4, 4'h1, 0, 0);
        add(1, 1, 4'h5, 4'h3, 0, 0);
        add(1, 1, 4'h6, 4'h4, 0, 0);
        for (int i = 7; i <= 12; i++) add(1, 0, 4'(i), 4'h4, i == 12, 0);
        add(1, 1, 4'hD, 4'h5, 1, 0);
        for (int i = 6; i <= 13; i++) add(0, 1, 4'h0, 4'(i), 0, i == 13);
        add(1, 1, 4'hE, 4'hD, 0, 0);
        add(0, 1, 4'h0, 4'hE, 0, 1);

        #3;
        chk("reset_async", 4'h0, 1'b0, 1'b1);
        wr_en = 1'b1; data_in = 4'h7;
        @(posedge clk);
        #1;
        chk("reset_hold", 4'h0, 1'b0, 1'b1);
        #1;
        rst_a = 1'b0;
        wr_en = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].wr, vq[i].rd, vq[i].din);
            chk($sformatf("vec%0d", i), vq[i].dout,
                vq[i].full, vq[i].empty);
        end

        step(1, 0, 4'h1);
        step(1, 0, 4'h2);
        step(1, 0, 4'h3);
        chk("pre_reset", 4'hE, 1'b0, 1'b0);
        #2;
        rst_a = 1'b1;
        #1;
        chk("mid_reset", 4'h0, 1'b0, 1'b1);
        wr_en = 1'b1; rd_en = 1'b1; data_in = 4'h9;
        @(posedge clk);
        #1;
        chk("mid_reset_hold", 4'h0, 1'b0, 1'b1);
        #1;
        rst_a = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0;
        step(1, 0, 4'h5);
        chk("post_reset_wr", 4'h0, 1'b0, 1'b0);
        step(0, 1, 4'h0);
        chk("post_reset_rd", 4'h5, 1'b0, 1'b1);
        step(0, 1, 4'h0);
        chk("post_reset_rd_empty", 4'h5, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
